// File: rtl/alu_result_buffer_pkg.sv
// alu_result_buffer_pkg: default sizing shared by the result buffer, its FIFO and the bench
package alu_result_buffer_pkg;
    localparam int RESBUF_DATA_WIDTH = 16;
    localparam int RESBUF_LATENCY    = 5;
    localparam int RESBUF_DEPTH      = 8;
    localparam int RESBUF_ADDR_WIDTH = 3;
    localparam int RESBUF_DEST_WIDTH = 4;
endpackage

// File: rtl/alu_result_buffer_fifo.sv
// resbuf_fifo: first-word-fall-through FIFO over registered storage, async active-low reset
// Ports: clk, rst (active-low), push/wdata, pop, rdata (head, zero when empty), full, empty, count
module resbuf_fifo #(
    parameter int WIDTH      = 36,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count
);
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wp, rp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wdata;
    end

    always_comb begin
        empty = count == '0;
        full  = count == (ADDR_WIDTH+1)'(DEPTH);
        rdata = empty ? '0 : mem[rp];
    end
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: tracks ops through complex_alu, queues {dest,dout} results, credit-stalls issue
// Ports: clk, rst (async active-low); issue_valid_i/issue_dest_i in, issue_stall_o out;
//        alu_dout_i in; res_valid_o/res_ready_i/res_data_o/res_dest_o handshake; count_o; overflow_o (sticky)
// Option: RESBUF_BYPASS_EN presents an arrival combinationally when the FIFO is empty
module alu_result_buffer
    import alu_result_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = RESBUF_DATA_WIDTH,
    parameter int ALU_LATENCY = RESBUF_LATENCY,
    parameter int DEPTH       = RESBUF_DEPTH,
    parameter int ADDR_WIDTH  = RESBUF_ADDR_WIDTH,
    parameter int DEST_WIDTH  = RESBUF_DEST_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid_i,
    input  logic [DEST_WIDTH-1:0]   issue_dest_i,
    output logic                    issue_stall_o,
    input  logic [2*DATA_WIDTH-1:0] alu_dout_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [2*DATA_WIDTH-1:0] res_data_o,
    output logic [DEST_WIDTH-1:0]   res_dest_o,
    output logic [ADDR_WIDTH:0]     count_o,
    output logic                    overflow_o
);
    localparam int W = 2*DATA_WIDTH;

    logic [ALU_LATENCY-1:0]  trk_v;
    logic [DEST_WIDTH-1:0]   trk_d [ALU_LATENCY];
    logic                    arrive, take, push, pop, full, empty;
    logic [W+DEST_WIDTH-1:0] fifo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_v      <= '0;
            overflow_o <= 1'b0;
            for (int i = 0; i < ALU_LATENCY; i++) trk_d[i] <= '0;
        end else begin
            trk_v    <= {trk_v[ALU_LATENCY-2:0], issue_valid_i};
            trk_d[0] <= issue_dest_i;
            for (int i = 1; i < ALU_LATENCY; i++) trk_d[i] <= trk_d[i-1];
            if (push && full && !pop) overflow_o <= 1'b1;
        end
    end

    always_comb begin
        arrive = trk_v[ALU_LATENCY-1];
        pop    = !empty && res_ready_i;
`ifdef RESBUF_BYPASS_EN
        take        = empty && arrive && res_ready_i;
        res_valid_o = !empty || arrive;
        res_data_o  = (empty && arrive) ? alu_dout_i : fifo_q[W-1:0];
        res_dest_o  = (empty && arrive) ? trk_d[ALU_LATENCY-1] : fifo_q[W+DEST_WIDTH-1:W];
`else
        take        = 1'b0;
        res_valid_o = !empty;
        res_data_o  = fifo_q[W-1:0];
        res_dest_o  = fifo_q[W+DEST_WIDTH-1:W];
`endif
        push = arrive && !take;
        // the tail stage is still counted: its result has not landed in the FIFO yet
        issue_stall_o = (int'(count_o) + $countones(trk_v)) >= DEPTH;
    end

    resbuf_fifo #(
        .WIDTH(W + DEST_WIDTH),
        .DEPTH(DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push && (!full || pop)),
        .wdata({trk_d[ALU_LATENCY-1], alu_dout_i}),
        .pop(pop),
        .rdata(fifo_q),
        .full(full),
        .empty(empty),
        .count(count_o)
    );
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed stimulus against a queue-based model of the result buffer
module tb_alu_result_buffer;
    import alu_result_buffer_pkg::*;
    localparam int L = RESBUF_LATENCY;

    typedef struct packed {
        logic [3:0]  d;
        logic [31:0] x;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic [3:0]  issue_dest_i = '0;
    logic        issue_stall_o;
    logic [31:0] alu_dout_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [31:0] res_data_o;
    logic [3:0]  res_dest_o;
    logic [3:0]  count_o;
    logic        overflow_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    ent_t        q[$];
    logic [31:0] sched_x [int];
    logic [3:0]  sched_d [int];
    logic        ovf = 1'b0;

    alu_result_buffer dut (
        .clk(clk),
        .rst(rst),
        .issue_valid_i(issue_valid_i),
        .issue_dest_i(issue_dest_i),
        .issue_stall_o(issue_stall_o),
        .alu_dout_i(alu_dout_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_data_o(res_data_o),
        .res_dest_o(res_dest_o),
        .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // an op issued in cycle c delivers its dout in cycle c+L
    task automatic step(input logic iv, input logic [3:0] d, input logic [31:0] x, input logic rdy);
        @(posedge clk);
        #1;
        issue_valid_i = iv;
        issue_dest_i  = d;
        res_ready_i   = rdy;
        if (iv) begin
            sched_x[cyc+L] = x;
            sched_d[cyc+L] = d;
        end
        alu_dout_i = sched_x.exists(cyc) ? sched_x[cyc] : $urandom;
    endtask

    always @(negedge rst) begin
        q.delete();
        sched_x.delete();
        sched_d.delete();
        ovf = 1'b0;
    end

    always @(posedge clk) begin : mdl
        logic arr, take, pop, push;
        if (rst) begin
            arr  = sched_x.exists(cyc);
            pop  = q.size() != 0 && res_ready_i;
            take = 1'b0;
`ifdef RESBUF_BYPASS_EN
            take = q.size() == 0 && arr && res_ready_i;
`endif
            push = arr && !take;
            if (push && q.size() == RESBUF_DEPTH && !pop) ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (push && q.size() < RESBUF_DEPTH) q.push_back({sched_d[cyc], sched_x[cyc]});
            if (arr) begin
                sched_x.delete(cyc);
                sched_d.delete(cyc);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : cmp
        int          infl;
        logic        arr, ev;
        logic [31:0] ex;
        logic [3:0]  ed;
        if (cyc > 0) begin
            infl = 0;
            foreach (sched_x[k]) if (k >= cyc && k < cyc + L) infl++;
            arr = sched_x.exists(cyc);
            ev  = q.size() != 0;
            ex  = ev ? q[0].x : 32'h0;
            ed  = ev ? q[0].d : 4'h0;
`ifdef RESBUF_BYPASS_EN
            if (!ev && arr) begin
                ev = 1'b1;
                ex = sched_x[cyc];
                ed = sched_d[cyc];
            end
`endif
            chk("res_valid", res_valid_o, ev);
            chk("res_data", res_data_o, ex);
            chk("res_dest", res_dest_o, ed);
            chk("count", count_o, q.size());
            chk("stall", issue_stall_o, (q.size() + infl) >= RESBUF_DEPTH);
            chk("overflow", overflow_o, ovf);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_valid", res_valid_o, 0);
        chk("rst_data", res_data_o, 0);
        chk("rst_stall", issue_stall_o, 0);
        #2 rst = 1'b1;

        step(1, 4'd3, 32'h1234_ABCD, 1);
        repeat (L) step(0, 0, 0, 1);
        @(negedge clk);
`ifdef RESBUF_BYPASS_EN
        chk("single_arrive_valid", res_valid_o, 1);
        chk("single_arrive_data", res_data_o, 32'h1234_ABCD);
`else
        chk("single_arrive_valid", res_valid_o, 0);
`endif
        step(0, 0, 0, 1);
        @(negedge clk);
`ifdef RESBUF_BYPASS_EN
        chk("single_next_valid", res_valid_o, 0);
`else
        chk("single_next_valid", res_valid_o, 1);
        chk("single_next_data", res_data_o, 32'h1234_ABCD);
        chk("single_next_dest", res_dest_o, 3);
`endif
        step(0, 0, 0, 1);
        @(negedge clk);
        chk("single_after_count", count_o, 0);
        chk("single_after_valid", res_valid_o, 0);

        for (int i = 0; i < 8; i++) step(1, 4'(i), 32'hA000_0000 + 32'(i), 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("fill_stall", issue_stall_o, 1);
        repeat (L) step(0, 0, 0, 0);
        @(negedge clk);
        chk("fill_count", count_o, 8);
        chk("fill_overflow", overflow_o, 0);

        step(1, 4'd8, 32'hB000_0008, 0);
        repeat (L - 1) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("pushpop_count", count_o, 8);
        chk("pushpop_overflow", overflow_o, 0);
        chk("pushpop_head", res_dest_o, 1);

        step(1, 4'd9, 32'hC000_0009, 0);
        repeat (L) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        chk("ovf_set", overflow_o, 1);
        chk("ovf_count", count_o, 8);
        repeat (10) step(0, 0, 0, 1);
        @(negedge clk);
        chk("ovf_sticky", overflow_o, 1);
        chk("ovf_drained", count_o, 0);

        step(1, 4'd10, 32'hD000_0010, 0);
        step(1, 4'd11, 32'hD000_0011, 0);
        repeat (L + 1) step(0, 0, 0, 0);
        @(negedge clk);
        chk("rstmid_queued", count_o, 2);
        step(1, 4'd12, 32'hD000_0012, 0);
        step(1, 4'd13, 32'hD000_0013, 0);
        step(1, 4'd14, 32'hD000_0014, 0);
        step(0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_valid", res_valid_o, 0);
        chk("rstmid_count", count_o, 0);
        chk("rstmid_data", res_data_o, 0);
        chk("rstmid_overflow", overflow_o, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (L + 3) step(0, 0, 0, 1);
        @(negedge clk);
        chk("rstmid_after_count", count_o, 0);
        chk("rstmid_after_valid", res_valid_o, 0);

`ifdef RESBUF_BYPASS_EN
        step(1, 4'd5, 32'hFFFF_0001, 1);
        repeat (L) step(0, 0, 0, 1);
        @(negedge clk);
        chk("bypass_valid", res_valid_o, 1);
        chk("bypass_data", res_data_o, 32'hFFFF_0001);
        chk("bypass_count", count_o, 0);
        step(0, 0, 0, 1);
        @(negedge clk);
        chk("bypass_after_count", count_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
